// File: rtl/l2_req_throttle.sv
// rtl/l2_req_throttle.sv - request FIFO with outstanding-request throttle ahead of l2_distribute
//
// Purpose:
//   Buffers TileLink A-channel request beats from the cluster-to-L2 network in a
//   small show-ahead FIFO. The FIFO head is presented to l2_distribute.
//   Each A-channel request produces exactly one D-channel response. The block
//   counts issued requests against responses accepted on mem_rsp_out. It stops
//   issuing while MAX_OUTSTANDING requests are unanswered.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_in_*                 upstream request beat (valid/ready + payload)
//   req_out_*                FIFO head towards l2_distribute mem_req_in (valid/ready + payload)
//   rsp_mon_valid_i/ready_i  snooped handshake of l2_distribute mem_rsp_out
//   outstanding_cnt_o        issued-but-unanswered request count
//   idle_o                   FIFO empty and nothing in flight
//   err_underflow_o          sticky: a response was seen while nothing was in flight

`ifndef OP_BITS
`define OP_BITS 3
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 4
`endif
`ifndef SOURCE_BITS
`define SOURCE_BITS 8
`endif
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 32
`endif
`ifndef MASK_BITS
`define MASK_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 64
`endif

module l2_req_throttle #(
    parameter int  DEPTH           = 4,
    parameter int  MAX_OUTSTANDING = 16,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1),
    localparam int PTR_W           = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     req_in_valid_i,
    output logic                     req_in_ready_o,
    input  logic [`OP_BITS-1:0]      req_in_opcode_i,
    input  logic [`SIZE_BITS-1:0]    req_in_size_i,
    input  logic [`SOURCE_BITS-1:0]  req_in_source_i,
    input  logic [`ADDRESS_BITS-1:0] req_in_address_i,
    input  logic [`MASK_BITS-1:0]    req_in_mask_i,
    input  logic [`DATA_BITS-1:0]    req_in_data_i,
    input  logic [2:0]               req_in_param_i,

    output logic                     req_out_valid_o,
    input  logic                     req_out_ready_i,
    output logic [`OP_BITS-1:0]      req_out_opcode_o,
    output logic [`SIZE_BITS-1:0]    req_out_size_o,
    output logic [`SOURCE_BITS-1:0]  req_out_source_o,
    output logic [`ADDRESS_BITS-1:0] req_out_address_o,
    output logic [`MASK_BITS-1:0]    req_out_mask_o,
    output logic [`DATA_BITS-1:0]    req_out_data_o,
    output logic [2:0]               req_out_param_o,

    input  logic                     rsp_mon_valid_i,
    input  logic                     rsp_mon_ready_i,

    output logic [CNT_W-1:0]         outstanding_cnt_o,
    output logic                     idle_o,
    output logic                     err_underflow_o
);

    localparam int PLD_W  = `OP_BITS + `SIZE_BITS + `SOURCE_BITS + `ADDRESS_BITS
                          + `MASK_BITS + `DATA_BITS + 3;
    localparam int FILL_W = PTR_W + 1;

    // Payload storage; deliberately not reset, only the pointers/fill qualify it.
    logic [PLD_W-1:0]  mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              err_q, err_d;

    logic              in_fire;
    logic              out_fire;
    logic              rsp_fire;
    logic              fifo_empty;
    logic              throttled;
    logic [PLD_W-1:0]  in_pld;
    logic [PLD_W-1:0]  head_pld;

    assign in_pld = {req_in_opcode_i, req_in_size_i, req_in_source_i, req_in_address_i,
                     req_in_mask_i, req_in_data_i, req_in_param_i};

    // Show-ahead read: the head entry is only overwritten once it has been popped,
    // so the payload stays stable while valid is held.
    assign head_pld = mem_q[rd_ptr_q];
    assign {req_out_opcode_o, req_out_size_o, req_out_source_o, req_out_address_o,
            req_out_mask_o, req_out_data_o, req_out_param_o} = head_pld;

    // All handshake outputs come from registered state only; a same-cycle pop
    // does not open in_ready and a same-cycle response does not lift the throttle.
    assign fifo_empty      = (fill_q == '0);
    assign throttled       = (out_cnt_q >= CNT_W'(MAX_OUTSTANDING));
    assign req_in_ready_o  = (fill_q < FILL_W'(DEPTH));
    assign req_out_valid_o = !fifo_empty && !throttled;

    assign in_fire  = req_in_valid_i && req_in_ready_o;
    assign out_fire = req_out_valid_o && req_out_ready_i;
    assign rsp_fire = rsp_mon_valid_i && rsp_mon_ready_i;

    assign outstanding_cnt_o = out_cnt_q;
    assign idle_o            = fifo_empty && (out_cnt_q == '0);
    assign err_underflow_o   = err_q;

    // FIFO pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (in_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (out_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (in_fire && !out_fire) begin
            fill_d = fill_q + FILL_W'(1);
        end else if (!in_fire && out_fire) begin
            fill_d = fill_q - FILL_W'(1);
        end
    end

    // In-flight accounting. A response with nothing in flight is a protocol
    // violation upstream: the counter saturates at zero and the sticky flag records it.
    always_comb begin
        out_cnt_d = out_cnt_q;
        err_d     = err_q;
        case ({out_fire, rsp_fire})
            2'b10: out_cnt_d = out_cnt_q + CNT_W'(1);
            2'b01: begin
                if (out_cnt_q == '0) begin
                    err_d = 1'b1;
                end else begin
                    out_cnt_d = out_cnt_q - CNT_W'(1);
                end
            end
            2'b11: begin
                if (out_cnt_q == '0) begin
                    err_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_q[wr_ptr_q] <= in_pld;
        end
    end

endmodule

// File: tb/tb_l2_req_throttle.sv
// tb/tb_l2_req_throttle.sv - self-checking bench for l2_req_throttle

`ifndef OP_BITS
`define OP_BITS 3
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 4
`endif
`ifndef SOURCE_BITS
`define SOURCE_BITS 8
`endif
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 32
`endif
`ifndef MASK_BITS
`define MASK_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 64
`endif

module tb_l2_req_throttle;

    localparam int DEPTH = 4;
    localparam int MAXO  = 16;
    localparam int CNT_W = $clog2(MAXO + 1);
    localparam int PLD_W = `OP_BITS + `SIZE_BITS + `SOURCE_BITS + `ADDRESS_BITS
                         + `MASK_BITS + `DATA_BITS + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic in_valid  = 1'b0;
    logic out_ready = 1'b0;
    logic rsp_valid = 1'b0;
    logic rsp_ready = 1'b0;
    logic [PLD_W-1:0] in_pld = '0;

    logic [`OP_BITS-1:0]      req_in_opcode_i,   req_out_opcode_o;
    logic [`SIZE_BITS-1:0]    req_in_size_i,     req_out_size_o;
    logic [`SOURCE_BITS-1:0]  req_in_source_i,   req_out_source_o;
    logic [`ADDRESS_BITS-1:0] req_in_address_i,  req_out_address_o;
    logic [`MASK_BITS-1:0]    req_in_mask_i,     req_out_mask_o;
    logic [`DATA_BITS-1:0]    req_in_data_i,     req_out_data_o;
    logic [2:0]               req_in_param_i,    req_out_param_o;
    logic                     req_in_ready_o, req_out_valid_o, idle_o, err_underflow_o;
    logic [CNT_W-1:0]         outstanding_cnt_o;
    logic [PLD_W-1:0]         out_pld;

    assign {req_in_opcode_i, req_in_size_i, req_in_source_i, req_in_address_i,
            req_in_mask_i, req_in_data_i, req_in_param_i} = in_pld;
    assign out_pld = {req_out_opcode_o, req_out_size_o, req_out_source_o, req_out_address_o,
                      req_out_mask_o, req_out_data_o, req_out_param_o};

    l2_req_throttle #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_in_valid_i    (in_valid),
        .req_in_ready_o    (req_in_ready_o),
        .req_in_opcode_i   (req_in_opcode_i),
        .req_in_size_i     (req_in_size_i),
        .req_in_source_i   (req_in_source_i),
        .req_in_address_i  (req_in_address_i),
        .req_in_mask_i     (req_in_mask_i),
        .req_in_data_i     (req_in_data_i),
        .req_in_param_i    (req_in_param_i),
        .req_out_valid_o   (req_out_valid_o),
        .req_out_ready_i   (out_ready),
        .req_out_opcode_o  (req_out_opcode_o),
        .req_out_size_o    (req_out_size_o),
        .req_out_source_o  (req_out_source_o),
        .req_out_address_o (req_out_address_o),
        .req_out_mask_o    (req_out_mask_o),
        .req_out_data_o    (req_out_data_o),
        .req_out_param_o   (req_out_param_o),
        .rsp_mon_valid_i   (rsp_valid),
        .rsp_mon_ready_i   (rsp_ready),
        .outstanding_cnt_o (outstanding_cnt_o),
        .idle_o            (idle_o),
        .err_underflow_o   (err_underflow_o)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of accepted beats, an integer in-flight count, a sticky flag.
    logic [PLD_W-1:0] mq[$];
    int m_out = 0;
    bit m_err = 1'b0;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        rv;
        logic [31:0] addr;
        logic        e_rdy;
        logic        e_vld;
        int          e_cnt;
        logic        e_idle;
        logic        c_addr;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic iv, input logic ordy, input logic rv,
                                input logic [31:0] addr, input logic e_rdy, input logic e_vld,
                                input int e_cnt, input logic e_idle, input logic c_addr,
                                input logic [31:0] e_addr);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.rv = rv; v.addr = addr;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_cnt = e_cnt; v.e_idle = e_idle;
        v.c_addr = c_addr; v.e_addr = e_addr;
        return v;
    endfunction

    function automatic logic [PLD_W-1:0] make_pld(input logic [31:0] a, input logic [7:0] s);
        return {`OP_BITS'(4), `SIZE_BITS'(2), `SOURCE_BITS'(s), `ADDRESS_BITS'(a),
                {`MASK_BITS{1'b1}}, `DATA_BITS'(a), 3'd0};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit e_valid;
        e_valid = (mq.size() > 0) && (m_out < MAXO);
        chk("in_ready", 128'(req_in_ready_o), 128'(mq.size() < DEPTH));
        chk("out_valid", 128'(req_out_valid_o), 128'(e_valid));
        if (e_valid) chk("payload", 128'(out_pld), 128'(mq[0]));
        chk("outstanding", 128'(outstanding_cnt_o), 128'(m_out));
        chk("idle", 128'(idle_o), 128'((mq.size() == 0) && (m_out == 0)));
        chk("err_underflow", 128'(err_underflow_o), 128'(m_err));
    endtask

    task automatic update_model();
        bit inf, outf, rspf;
        inf  = in_valid && (mq.size() < DEPTH);
        outf = out_ready && (mq.size() > 0) && (m_out < MAXO);
        rspf = rsp_valid && rsp_ready;
        if (outf) void'(mq.pop_front());
        if (inf) mq.push_back(in_pld);
        if (outf && !rspf) m_out++;
        else if (rspf && !outf) begin
            if (m_out == 0) m_err = 1'b1;
            else m_out--;
        end else if (rspf && outf && (m_out == 0)) m_err = 1'b1;
    endtask

    task automatic cyc();
        @(negedge clk);
        check_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; rsp_valid = 1'b0; rsp_ready = 1'b0;
        rst = 1'b1;
        mq.delete(); m_out = 0; m_err = 1'b0;
        @(negedge clk);
        check_model();
        rst = 1'b0;
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic set_rsp(input logic v);
        rsp_valid = v;
        rsp_ready = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int fires;
        logic [127:0] r;

        //            iv ordy rv addr          rdy vld cnt idle c_addr e_addr
        tbl[0]  = mk(0, 0, 0, 32'h0,        1, 0, 0, 1, 0, 32'h0);
        tbl[1]  = mk(1, 1, 0, 32'h1000,     1, 0, 0, 1, 0, 32'h0);
        tbl[2]  = mk(0, 1, 0, 32'h0,        1, 1, 0, 0, 1, 32'h1000);
        tbl[3]  = mk(0, 0, 0, 32'h0,        1, 0, 1, 0, 0, 32'h0);
        tbl[4]  = mk(0, 0, 1, 32'h0,        1, 0, 1, 0, 0, 32'h0);
        tbl[5]  = mk(0, 0, 0, 32'h0,        1, 0, 0, 1, 0, 32'h0);
        tbl[6]  = mk(1, 0, 0, 32'hA000,     1, 0, 0, 1, 0, 32'h0);
        tbl[7]  = mk(1, 0, 0, 32'hA040,     1, 1, 0, 0, 1, 32'hA000);
        tbl[8]  = mk(1, 0, 0, 32'hA080,     1, 1, 0, 0, 1, 32'hA000);
        tbl[9]  = mk(1, 0, 0, 32'hA0C0,     1, 1, 0, 0, 1, 32'hA000);
        tbl[10] = mk(1, 0, 0, 32'hDEAD,     0, 1, 0, 0, 1, 32'hA000);
        tbl[11] = mk(0, 1, 0, 32'h0,        0, 1, 0, 0, 1, 32'hA000);
        tbl[12] = mk(0, 1, 0, 32'h0,        1, 1, 1, 0, 1, 32'hA040);
        tbl[13] = mk(0, 1, 0, 32'h0,        1, 1, 2, 0, 1, 32'hA080);
        tbl[14] = mk(0, 1, 0, 32'h0,        1, 1, 3, 0, 1, 32'hA0C0);
        tbl[15] = mk(0, 0, 0, 32'h0,        1, 0, 4, 0, 0, 32'h0);

        // Reset state and table-driven single Get / fill-and-drain sequence.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            set_rsp(tbl[i].rv);
            in_pld    = make_pld(tbl[i].addr, 8'd3);
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", i), 128'(req_in_ready_o), 128'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_out_valid", i), 128'(req_out_valid_o), 128'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_cnt", i), 128'(outstanding_cnt_o), 128'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_idle", i), 128'(idle_o), 128'(tbl[i].e_idle));
            if (tbl[i].c_addr) begin
                chk($sformatf("tbl%0d_addr", i), 128'(req_out_address_o), 128'(tbl[i].e_addr));
                chk($sformatf("tbl%0d_source", i), 128'(req_out_source_o), 128'(3));
            end
            check_model();
            @(posedge clk);
            update_model();
            #1;
        end

        // Throttle at MAX_OUTSTANDING, then a single response releases exactly one request.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (outstanding_cnt_o != CNT_W'(MAXO) && n < 60) begin
            in_pld = make_pld(32'h2000 + 32'(n), 8'd1);
            cyc();
            n++;
        end
        chk("throttle_reach", 128'(outstanding_cnt_o), 128'(MAXO));
        repeat (6) cyc();
        chk("throttle_valid_low", 128'(req_out_valid_o), 128'(0));
        chk("throttle_nonempty", 128'(idle_o), 128'(0));
        chk("throttle_fifo_full", 128'(req_in_ready_o), 128'(0));
        in_valid = 1'b0;
        set_rsp(1'b1);
        cyc();
        set_rsp(1'b0);
        chk("release_valid", 128'(req_out_valid_o), 128'(1));
        chk("release_cnt", 128'(outstanding_cnt_o), 128'(MAXO - 1));
        fires = 0;
        repeat (5) begin
            if (req_out_valid_o) fires++;
            cyc();
        end
        chk("release_one_issue", 128'(fires), 128'(1));
        chk("release_cnt_back", 128'(outstanding_cnt_o), 128'(MAXO));

        // Simultaneous out_fire and rsp_fire at count 5.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (6) begin
            in_pld = make_pld($urandom(), 8'd5);
            cyc();
        end
        chk("cnt5_before", 128'(outstanding_cnt_o), 128'(5));
        chk("cnt5_valid", 128'(req_out_valid_o), 128'(1));
        set_rsp(1'b1);
        cyc();
        set_rsp(1'b0);
        chk("cnt5_after_both", 128'(outstanding_cnt_o), 128'(5));

        // Simultaneous in_fire and out_fire at fill 2.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0;
        repeat (2) begin
            in_pld = make_pld($urandom(), 8'd6);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        cyc();
        chk("fill2_then_3_ready", 128'(req_in_ready_o), 128'(1));
        cyc();
        chk("fill2_then_4_full", 128'(req_in_ready_o), 128'(0));

        // Underflow: response with nothing in flight, alone and together with an issue.
        do_reset();
        set_rsp(1'b1);
        cyc();
        set_rsp(1'b0);
        chk("uflow_err", 128'(err_underflow_o), 128'(1));
        chk("uflow_cnt", 128'(outstanding_cnt_o), 128'(0));
        repeat (3) cyc();
        chk("uflow_sticky", 128'(err_underflow_o), 128'(1));
        do_reset();
        in_valid = 1'b1;
        in_pld = make_pld(32'h3000, 8'd7);
        cyc();
        in_valid = 1'b0; out_ready = 1'b1;
        set_rsp(1'b1);
        cyc();
        set_rsp(1'b0); out_ready = 1'b0;
        chk("uflow_both_err", 128'(err_underflow_o), 128'(1));
        chk("uflow_both_cnt", 128'(outstanding_cnt_o), 128'(0));

        // Asynchronous reset mid-traffic at fill 3, count 7.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0;
        repeat (3) begin
            in_pld = make_pld($urandom(), 8'd9);
            cyc();
        end
        out_ready = 1'b1;
        repeat (7) begin
            in_pld = make_pld($urandom(), 8'd9);
            cyc();
        end
        chk("mid_cnt7", 128'(outstanding_cnt_o), 128'(7));
        rst = 1'b1;
        #2;
        chk("mid_rst_valid", 128'(req_out_valid_o), 128'(0));
        chk("mid_rst_cnt", 128'(outstanding_cnt_o), 128'(0));
        chk("mid_rst_idle", 128'(idle_o), 128'(1));
        chk("mid_rst_ready", 128'(req_in_ready_o), 128'(1));
        do_reset();

        // Randomized traffic against the queue model: sparse responses, then balanced.
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            for (int k = 0; k < 1500; k++) begin
                r = {$urandom(), $urandom(), $urandom(), $urandom()};
                in_pld    = r[PLD_W-1:0];
                in_valid  = ($urandom_range(0, 99) < 60);
                out_ready = ($urandom_range(0, 99) < 70);
                rsp_valid = ($urandom_range(0, 99) < (ph == 0 ? 15 : 55));
                rsp_ready = ($urandom_range(0, 99) < 80);
                cyc();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
